// File: rtl/axi_slv_pkg.sv
// Shared encodings and helpers for the parametrised AXI4 SRAM slave.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_t;

    function automatic int unsigned lane_log2(input int unsigned nbytes);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < nbytes) r = i + 1;
        end
        return r;
    endfunction

    // DECERR dominates SLVERR, which dominates OKAY.
    function automatic logic [1:0] resp_of(input logic slverr, input logic decerr);
        if (decerr) return RESP_DECERR;
        if (slverr) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address: FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [1:0]            burst,
    input  logic [2:0]            size,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        // Wrap window is (len+1) beats; legal wrap lengths make it a power of two.
        mask      = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        incr      = addr + step;
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave_mc.sv
// AXI4 slave over a single-port byte-write SRAM with read/write arbitration,
// FIXED/INCR/WRAP bursts and per-burst error responses.
module axi_sram_slave_mc
    import axi_slv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     S_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AWAddr,
    input  logic [LEN_WIDTH-1:0]    S_AWLen,
    input  logic [2:0]              S_AWSize,
    input  logic [1:0]              S_AWBurst,
    input  logic                    S_AWValid,
    output logic                    S_AWReady,
    input  logic [DATA_WIDTH-1:0]   S_WData,
    input  logic [DATA_WIDTH/8-1:0] S_WStrb,
    input  logic                    S_WLast,
    input  logic                    S_WValid,
    output logic                    S_WReady,
    output logic [ID_WIDTH-1:0]     S_BID,
    output logic [1:0]              S_BResp,
    output logic                    S_BValid,
    input  logic                    S_BReady,
    input  logic [ID_WIDTH-1:0]     S_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_ARAddr,
    input  logic [LEN_WIDTH-1:0]    S_ARLen,
    input  logic [2:0]              S_ARSize,
    input  logic [1:0]              S_ARBurst,
    input  logic                    S_ARValid,
    output logic                    S_ARReady,
    output logic [ID_WIDTH-1:0]     S_RID,
    output logic [DATA_WIDTH-1:0]   S_RData,
    output logic [1:0]              S_RResp,
    output logic                    S_RLast,
    output logic                    S_RValid,
    input  logic                    S_RReady
);

    localparam int unsigned NB      = DATA_WIDTH / 8;
    localparam int unsigned LB      = lane_log2(NB);
    localparam int unsigned IW      = ADDR_WIDTH - LB;
    localparam int unsigned MW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IW:0] DEPTH_L = (IW + 1)'(MEM_DEPTH);
    localparam logic [2:0]  SIZE_OK = 3'(LB);

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a[ADDR_WIDTH-1:LB]} >= DEPTH_L;
    endfunction

    function automatic logic wrap_len_ok(input logic [LEN_WIDTH-1:0] l);
        int unsigned v;
        v = 32'(l);
        return (v == 1) || (v == 3) || (v == 7) || (v == 15);
    endfunction

    state_t                  state;
    logic                    prio_read;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    slverr_q;
    logic                    decerr_q;
    logic [1:0]              rresp_q;
    logic                    rzero_q;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    aw_hs;
    logic                    ar_hs;
    logic                    w_hs;
    logic                    r_hs;
    logic                    r_last;
    logic                    cur_oob;
    logic                    mem_we;
    logic                    rd_issue;
    logic                    acc_slverr;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [LEN_WIDTH-1:0]    acc_len;
    logic [2:0]              acc_size;
    logic [1:0]              acc_burst;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [MW-1:0]           mem_idx;

    always_comb begin
        aw_hs      = (state == ST_IDLE) && S_AWValid && (!S_ARValid || !prio_read);
        ar_hs      = (state == ST_IDLE) && S_ARValid && (!S_AWValid || prio_read);
        w_hs       = (state == ST_WDATA) && S_WValid;
        r_hs       = (state == ST_RDATA) && S_RReady;
        r_last     = (beat_q == len_q);
        acc_addr   = aw_hs ? S_AWAddr  : S_ARAddr;
        acc_len    = aw_hs ? S_AWLen   : S_ARLen;
        acc_size   = aw_hs ? S_AWSize  : S_ARSize;
        acc_burst  = aw_hs ? S_AWBurst : S_ARBurst;
        acc_slverr = (acc_size != SIZE_OK) || (acc_burst == BURST_RSVD) ||
                     ((acc_burst == BURST_WRAP) && !wrap_len_ok(acc_len));
        cur_oob    = out_of_range(addr_q);
        mem_idx    = addr_q[LB +: MW];
        mem_we     = w_hs && ARESETn && !slverr_q && !cur_oob;
        rd_issue   = (state == ST_RADDR) || (r_hs && !r_last);
    end

    assign S_AWReady = aw_hs;
    assign S_ARReady = ar_hs;
    assign S_WReady  = (state == ST_WDATA);
    assign S_BValid  = (state == ST_WRESP);
    assign S_BID     = (state == ST_WRESP) ? id_q : '0;
    assign S_BResp   = (state == ST_WRESP) ? resp_of(slverr_q, decerr_q) : RESP_OKAY;
    assign S_RValid  = (state == ST_RDATA);
    assign S_RID     = (state == ST_RDATA) ? id_q : '0;
    assign S_RResp   = (state == ST_RDATA) ? rresp_q : RESP_OKAY;
    assign S_RLast   = (state == ST_RDATA) && r_last;
    assign S_RData   = ((state == ST_RDATA) && !rzero_q) ? mem_q : '0;

    axi_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .size      (size_q),
        .next_addr (next_addr)
    );

    // The array is not reset; mem_q only changes on a read issue, which keeps
    // RData stable while the master stalls.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (S_WStrb[i]) mem[mem_idx][8*i +: 8] <= S_WData[8*i +: 8];
            end
        end
        if (rd_issue) mem_q <= mem[mem_idx];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            prio_read <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rzero_q   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs || ar_hs) begin
                        id_q     <= aw_hs ? S_AWID : S_ARID;
                        addr_q   <= acc_addr;
                        len_q    <= acc_len;
                        size_q   <= acc_size;
                        burst_q  <= acc_burst;
                        beat_q   <= '0;
                        slverr_q <= acc_slverr;
                        decerr_q <= 1'b0;
                        if (S_AWValid && S_ARValid) prio_read <= !prio_read;
                        state    <= aw_hs ? ST_WDATA : ST_RADDR;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        addr_q <= next_addr;
                        if (cur_oob) decerr_q <= 1'b1;
                        if (S_WLast) begin
                            if (beat_q != len_q) slverr_q <= 1'b1;
                            state <= ST_WRESP;
                        end else if (beat_q == len_q) begin
                            // Overrun: keep counting nothing, drop beats until WLAST.
                            slverr_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_WRESP: begin
                    if (S_BReady) state <= ST_IDLE;
                end
                ST_RADDR: begin
                    state <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        if (r_last) state <= ST_IDLE;
                        else        beat_q <= beat_q + LEN_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (rd_issue) begin
                addr_q   <= next_addr;
                decerr_q <= decerr_q | cur_oob;
                rresp_q  <= resp_of(slverr_q, decerr_q | cur_oob);
                rzero_q  <= slverr_q | decerr_q | cur_oob;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave_mc.sv
// Directed self-checking bench for axi_sram_slave_mc (32-bit data, 1024 words).
module tb_axi_sram_slave_mc;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  S_AWID;
    logic [15:0] S_AWAddr;
    logic [3:0]  S_AWLen;
    logic [2:0]  S_AWSize;
    logic [1:0]  S_AWBurst;
    logic        S_AWValid;
    logic        S_AWReady;
    logic [31:0] S_WData;
    logic [3:0]  S_WStrb;
    logic        S_WLast;
    logic        S_WValid;
    logic        S_WReady;
    logic [7:0]  S_BID;
    logic [1:0]  S_BResp;
    logic        S_BValid;
    logic        S_BReady;
    logic [7:0]  S_ARID;
    logic [15:0] S_ARAddr;
    logic [3:0]  S_ARLen;
    logic [2:0]  S_ARSize;
    logic [1:0]  S_ARBurst;
    logic        S_ARValid;
    logic        S_ARReady;
    logic [7:0]  S_RID;
    logic [31:0] S_RData;
    logic [1:0]  S_RResp;
    logic        S_RLast;
    logic        S_RValid;
    logic        S_RReady;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave_mc #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .ID_WIDTH   (8),
        .LEN_WIDTH  (4),
        .MEM_DEPTH  (1024)
    ) dut (
        .ACLK      (ACLK),      .ARESETn   (ARESETn),
        .S_AWID    (S_AWID),    .S_AWAddr  (S_AWAddr),  .S_AWLen   (S_AWLen),
        .S_AWSize  (S_AWSize),  .S_AWBurst (S_AWBurst), .S_AWValid (S_AWValid),
        .S_AWReady (S_AWReady),
        .S_WData   (S_WData),   .S_WStrb   (S_WStrb),   .S_WLast   (S_WLast),
        .S_WValid  (S_WValid),  .S_WReady  (S_WReady),
        .S_BID     (S_BID),     .S_BResp   (S_BResp),   .S_BValid  (S_BValid),
        .S_BReady  (S_BReady),
        .S_ARID    (S_ARID),    .S_ARAddr  (S_ARAddr),  .S_ARLen   (S_ARLen),
        .S_ARSize  (S_ARSize),  .S_ARBurst (S_ARBurst), .S_ARValid (S_ARValid),
        .S_ARReady (S_ARReady),
        .S_RID     (S_RID),     .S_RData   (S_RData),   .S_RResp   (S_RResp),
        .S_RLast   (S_RLast),   .S_RValid  (S_RValid),  .S_RReady  (S_RReady)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        ok = 1'b0;
        S_AWID = id; S_AWAddr = addr; S_AWLen = len; S_AWSize = size; S_AWBurst = burst;
        S_AWValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            ok = S_AWReady;
            tick;
        end
        S_AWValid = 1'b0;
        chk("aw_handshake", {63'd0, ok}, 64'd1);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        ok = 1'b0;
        S_ARID = id; S_ARAddr = addr; S_ARLen = len; S_ARSize = size; S_ARBurst = burst;
        S_ARValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            ok = S_ARReady;
            tick;
        end
        S_ARValid = 1'b0;
        chk("ar_handshake", {63'd0, ok}, 64'd1);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic ok;
        ok = 1'b0;
        S_WData = data; S_WStrb = strb; S_WLast = last; S_WValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            ok = S_WReady;
            tick;
        end
        S_WValid = 1'b0; S_WLast = 1'b0;
        chk("w_handshake", {63'd0, ok}, 64'd1);
    endtask

    task automatic b_chk(input logic [7:0] id, input logic [1:0] resp, input string tag);
        logic ok;
        ok = 1'b0;
        S_BReady = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (S_BValid) begin
                ok = 1'b1;
                chk({tag, "_bresp"}, {62'd0, S_BResp}, {62'd0, resp});
                chk({tag, "_bid"}, {56'd0, S_BID}, {56'd0, id});
            end
            tick;
        end
        S_BReady = 1'b0;
        chk({tag, "_bvalid"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last,
                          input logic [7:0] id, input string tag);
        logic ok;
        ok = 1'b0;
        S_RReady = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (S_RValid) begin
                ok = 1'b1;
                chk({tag, "_rdata"}, {32'd0, S_RData}, {32'd0, data});
                chk({tag, "_rresp"}, {62'd0, S_RResp}, {62'd0, resp});
                chk({tag, "_rlast"}, {63'd0, S_RLast}, {63'd0, last});
                chk({tag, "_rid"}, {56'd0, S_RID}, {56'd0, id});
            end
            tick;
        end
        chk({tag, "_rvalid"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic wr(input logic [7:0] id, input logic [15:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input logic [2:0] size, input logic [127:0] d,
                      input logic [3:0] strb, input logic [1:0] resp, input string tag);
        aw_send(id, addr, len, size, burst);
        for (int unsigned i = 0; i <= 32'(len); i++) w_beat(d[32*i +: 32], strb, i == 32'(len));
        b_chk(id, resp, tag);
    endtask

    task automatic rd(input logic [7:0] id, input logic [15:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input logic [2:0] size, input logic [127:0] d,
                      input logic [1:0] resp, input string tag);
        ar_send(id, addr, len, size, burst);
        for (int unsigned i = 0; i <= 32'(len); i++) r_beat(d[32*i +: 32], resp, i == 32'(len), id, tag);
        S_RReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESETn = 1'b0;
        S_AWID = '0; S_AWAddr = '0; S_AWLen = '0; S_AWSize = 3'd2; S_AWBurst = 2'b01; S_AWValid = 1'b0;
        S_WData = '0; S_WStrb = '0; S_WLast = 1'b0; S_WValid = 1'b0; S_BReady = 1'b0;
        S_ARID = '0; S_ARAddr = '0; S_ARLen = '0; S_ARSize = 3'd2; S_ARBurst = 2'b01; S_ARValid = 1'b0;
        S_RReady = 1'b0;
        tick; tick; tick;

        // Reset state
        chk("rst_awready", {63'd0, S_AWReady}, 64'd0);
        chk("rst_arready", {63'd0, S_ARReady}, 64'd0);
        chk("rst_wready",  {63'd0, S_WReady},  64'd0);
        chk("rst_bvalid",  {63'd0, S_BValid},  64'd0);
        chk("rst_rvalid",  {63'd0, S_RValid},  64'd0);
        chk("rst_rlast",   {63'd0, S_RLast},   64'd0);
        chk("rst_rdata",   {32'd0, S_RData},   64'd0);
        chk("rst_resp",    {60'd0, S_BResp, S_RResp}, 64'd0);
        chk("rst_ids",     {48'd0, S_BID, S_RID},     64'd0);
        ARESETn = 1'b1;
        tick;

        // INCR write then read, with first-beat latency check
        wr(8'h12, 16'h0010, 4'd3, 2'b01, 3'd2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 2'b00, "incr_wr");
        ar_send(8'h34, 16'h0010, 4'd3, 3'd2, 2'b01);
        #1 chk("lat_cycle1_rvalid", {63'd0, S_RValid}, 64'd0);
        tick;
        #1 chk("lat_cycle2_rvalid", {63'd0, S_RValid}, 64'd1);
        r_beat(32'hA0, 2'b00, 1'b0, 8'h34, "incr_rd0");
        r_beat(32'hA1, 2'b00, 1'b0, 8'h34, "incr_rd1");
        r_beat(32'hA2, 2'b00, 1'b0, 8'h34, "incr_rd2");
        r_beat(32'hA3, 2'b00, 1'b1, 8'h34, "incr_rd3");
        S_RReady = 1'b0;

        // WRAP len 3 at 0x18: 0x18, 0x1C, 0x10, 0x14
        wr(8'h21, 16'h0018, 4'd3, 2'b10, 3'd2, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'hF, 2'b00, "wrap_wr");
        rd(8'h22, 16'h0018, 4'd3, 2'b10, 3'd2, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2'b00, "wrap_rd");

        // INCR read over the wrapped region with a 5-cycle RReady stall after beat 0
        ar_send(8'h23, 16'h0010, 4'd3, 3'd2, 2'b01);
        r_beat(32'hB2, 2'b00, 1'b0, 8'h23, "stall_rd0");
        S_RReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rvalid", {63'd0, S_RValid}, 64'd1);
            chk("stall_rdata", {32'd0, S_RData}, {32'd0, 32'hB3});
            tick;
        end
        r_beat(32'hB3, 2'b00, 1'b0, 8'h23, "stall_rd1");
        r_beat(32'hB0, 2'b00, 1'b0, 8'h23, "stall_rd2");
        r_beat(32'hB1, 2'b00, 1'b1, 8'h23, "stall_rd3");
        S_RReady = 1'b0;

        // Byte strobes
        wr(8'h30, 16'h0020, 4'd0, 2'b01, 3'd2, {96'd0, 32'h11111111}, 4'hF, 2'b00, "strb_base");
        wr(8'h31, 16'h0020, 4'd0, 2'b01, 3'd2, {96'd0, 32'hDEADBEEF}, 4'b0101, 2'b00, "strb_wr");
        rd(8'h32, 16'h0020, 4'd0, 2'b01, 3'd2, {96'd0, 32'h11AD11EF}, 2'b00, "strb_rd");

        // DECERR at word 1024; word 0 must not be aliased
        wr(8'h40, 16'h0000, 4'd0, 2'b01, 3'd2, {96'd0, 32'h00C0FFEE}, 4'hF, 2'b00, "w0_base");
        wr(8'h41, 16'h1000, 4'd0, 2'b01, 3'd2, {96'd0, 32'h55555555}, 4'hF, 2'b11, "dec_wr");
        rd(8'h42, 16'h1000, 4'd0, 2'b01, 3'd2, 128'd0, 2'b11, "dec_rd");
        rd(8'h43, 16'h0000, 4'd0, 2'b01, 3'd2, {96'd0, 32'h00C0FFEE}, 2'b00, "dec_noalias");

        // SLVERR: bad size, reserved burst, illegal wrap length
        wr(8'h50, 16'h0024, 4'd0, 2'b01, 3'd2, {96'd0, 32'h24242424}, 4'hF, 2'b00, "w24_base");
        wr(8'h51, 16'h0024, 4'd0, 2'b01, 3'd1, {96'd0, 32'h77777777}, 4'hF, 2'b10, "size_wr");
        wr(8'h52, 16'h0024, 4'd2, 2'b10, 3'd2, {32'd0, 32'h99, 32'h98, 32'h97}, 4'hF, 2'b10, "wraplen_wr");
        rd(8'h53, 16'h0024, 4'd0, 2'b01, 3'd2, {96'd0, 32'h24242424}, 2'b00, "slv_unchanged");
        rd(8'h54, 16'h0024, 4'd0, 2'b01, 3'd1, 128'd0, 2'b10, "size_rd");
        rd(8'h55, 16'h0010, 4'd0, 2'b11, 3'd2, 128'd0, 2'b10, "rsvd_rd");

        // Early WLAST (2 beats of len 3)
        aw_send(8'h60, 16'h0040, 4'd3, 3'd2, 2'b01);
        w_beat(32'hD0, 4'hF, 1'b0);
        w_beat(32'hD1, 4'hF, 1'b1);
        b_chk(8'h60, 2'b10, "early_last");

        // Missing WLAST: len 1 with 3 beats, third beat discarded
        wr(8'h61, 16'h0050, 4'd0, 2'b01, 3'd2, {96'd0, 32'h50505050}, 4'hF, 2'b00, "w50_base");
        aw_send(8'h62, 16'h0048, 4'd1, 3'd2, 2'b01);
        w_beat(32'hC0, 4'hF, 1'b0);
        w_beat(32'hC1, 4'hF, 1'b0);
        w_beat(32'hC2, 4'hF, 1'b1);
        b_chk(8'h62, 2'b10, "overrun");
        rd(8'h63, 16'h0048, 4'd1, 2'b01, 3'd2, {64'd0, 32'hC1, 32'hC0}, 2'b00, "overrun_rd");
        rd(8'h64, 16'h0050, 4'd0, 2'b01, 3'd2, {96'd0, 32'h50505050}, 2'b00, "overrun_discard");

        // Reset in mid-read aborts the burst
        ar_send(8'h70, 16'h0010, 4'd3, 3'd2, 2'b01);
        r_beat(32'hB2, 2'b00, 1'b0, 8'h70, "abort_rd0");
        S_RReady = 1'b0;
        ARESETn = 1'b0;
        tick;
        #1;
        chk("abort_rvalid", {63'd0, S_RValid}, 64'd0);
        chk("abort_rdata", {32'd0, S_RData}, 64'd0);
        chk("abort_rlast", {63'd0, S_RLast}, 64'd0);
        ARESETn = 1'b1;
        tick;

        // Contention out of reset: read wins first
        S_AWID = 8'h81; S_AWAddr = 16'h0060; S_AWLen = 4'd0; S_AWSize = 3'd2; S_AWBurst = 2'b01;
        S_ARID = 8'h82; S_ARAddr = 16'h0010; S_ARLen = 4'd0; S_ARSize = 3'd2; S_ARBurst = 2'b01;
        S_AWValid = 1'b1; S_ARValid = 1'b1;
        #1;
        chk("arb1_arready", {63'd0, S_ARReady}, 64'd1);
        chk("arb1_awready", {63'd0, S_AWReady}, 64'd0);
        tick;
        S_ARValid = 1'b0;
        #1 chk("arb1_aw_blocked", {63'd0, S_AWReady}, 64'd0);
        r_beat(32'hB2, 2'b00, 1'b1, 8'h82, "arb1_rd");
        S_RReady = 1'b0;
        aw_send(8'h81, 16'h0060, 4'd0, 3'd2, 2'b01);
        w_beat(32'h60606060, 4'hF, 1'b1);
        b_chk(8'h81, 2'b00, "arb1_wr");

        // Contention again: write wins this time
        S_AWID = 8'h91; S_AWAddr = 16'h0064; S_AWLen = 4'd0; S_AWSize = 3'd2; S_AWBurst = 2'b01;
        S_ARID = 8'h92; S_ARAddr = 16'h0060; S_ARLen = 4'd0; S_ARSize = 3'd2; S_ARBurst = 2'b01;
        S_AWValid = 1'b1; S_ARValid = 1'b1;
        #1;
        chk("arb2_awready", {63'd0, S_AWReady}, 64'd1);
        chk("arb2_arready", {63'd0, S_ARReady}, 64'd0);
        tick;
        S_AWValid = 1'b0;
        w_beat(32'h64646464, 4'hF, 1'b1);
        b_chk(8'h91, 2'b00, "arb2_wr");
        rd(8'h92, 16'h0060, 4'd0, 2'b01, 3'd2, {96'd0, 32'h60606060}, 2'b00, "arb2_rd");
        rd(8'h93, 16'h0064, 4'd0, 2'b01, 3'd2, {96'd0, 32'h64646464}, 2'b00, "arb2_rd2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
